// File: rtl/down_count_checker_if.sv
// Sample/status bundle between a 4-bit down-counter source and its checker.
// master drives the counter bits and strobes; slave returns lock/error status.
interface down_count_checker_if #(
    parameter int ERR_W = 8
);
    logic             en;
    logic             dut_rst;
    logic             in0;
    logic             in1;
    logic             in2;
    logic             in3;
    logic             err_clr;
    logic             locked;
    logic             err;
    logic             wrap;
    logic [ERR_W-1:0] err_count;
    logic [3:0]       expected;

    modport master (
        output en, dut_rst, in0, in1, in2, in3, err_clr,
        input  locked, err, wrap, err_count, expected
    );

    modport slave (
        input  en, dut_rst, in0, in1, in2, in3, err_clr,
        output locked, err, wrap, err_count, expected
    );
endinterface

// File: rtl/down_count_checker.sv
// Monitor for a 4-bit down counter: acquires lock on LOCK_CNT good decrements,
// then pulses err on any out-of-sequence sample and wrap on 0 -> 15.
module down_count_checker #(
    parameter int LOCK_CNT = 2,
    parameter int RST_VAL  = 15,
    parameter int ERR_W    = 8
) (
    input  logic                 clk,
    input  logic                 rst,
    down_count_checker_if.slave  bus
);
    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        ACQUIRE = 2'd1,
        LOCKED  = 2'd2
    } state_t;

    localparam logic [3:0] RST_V  = 4'(RST_VAL);
    localparam logic [3:0] LOCK_V = 4'(LOCK_CNT);

    state_t           state;
    logic [3:0]       prev;
    logic [3:0]       expected_q;
    logic [3:0]       good_cnt;
    logic             locked_q;
    logic             err_q;
    logic             wrap_q;
    logic [ERR_W-1:0] err_count_q;

    logic [3:0]       v;
    logic             match;
    logic             lock_miss;

    assign v = {bus.in3, bus.in2, bus.in1, bus.in0};

    // A repeated value can never be a legal decrement, even when it happens
    // to equal expected (reset value held across a dut_rst release).
    always_comb begin
        match = 1'b0;
        if (bus.dut_rst)
            match = (v == RST_V);
        else
            match = (v == expected_q) && (v != prev);
    end

    assign lock_miss = bus.en && (state == LOCKED) && !match;

    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= IDLE;
            prev        <= 4'd0;
            expected_q  <= 4'd0;
            good_cnt    <= 4'd0;
            locked_q    <= 1'b0;
            err_q       <= 1'b0;
            wrap_q      <= 1'b0;
            err_count_q <= '0;
        end else begin
            err_q  <= 1'b0;
            wrap_q <= 1'b0;

            // Clear wins over a coincident increment; independent of en.
            if (bus.err_clr)
                err_count_q <= '0;
            else if (lock_miss && (err_count_q != {ERR_W{1'b1}}))
                err_count_q <= err_count_q + 1'b1;

            if (bus.en) begin
                prev       <= v;
                expected_q <= bus.dut_rst ? RST_V : (v - 4'd1);

                case (state)
                    IDLE: begin
                        state    <= ACQUIRE;
                        good_cnt <= 4'd0;
                        locked_q <= 1'b0;
                    end
                    ACQUIRE: begin
                        if (match) begin
                            if ((good_cnt + 4'd1) == LOCK_V) begin
                                state    <= LOCKED;
                                good_cnt <= 4'd0;
                                locked_q <= 1'b1;
                            end else begin
                                good_cnt <= good_cnt + 4'd1;
                            end
                        end else begin
                            good_cnt <= 4'd0;
                        end
                    end
                    LOCKED: begin
                        if (match) begin
                            wrap_q <= (prev == 4'd0) && (v == 4'd15) && !bus.dut_rst;
                        end else begin
                            err_q    <= 1'b1;
                            state    <= ACQUIRE;
                            good_cnt <= 4'd0;
                            locked_q <= 1'b0;
                        end
                    end
                    default: begin
                        state    <= IDLE;
                        good_cnt <= 4'd0;
                        locked_q <= 1'b0;
                    end
                endcase
            end
        end
    end

    assign bus.locked    = locked_q;
    assign bus.err       = err_q;
    assign bus.wrap      = wrap_q;
    assign bus.err_count = err_count_q;
    assign bus.expected  = expected_q;
endmodule

// File: doc/down_count_checker.md
Name: down_count_checker

Overview:
- Receive-side monitor for the 4-bit synchronous down counter (15 -> 0, wrap to 15).
- Samples the counter's four output bits on qualified clock edges.
- Acquires lock on a valid descending sequence, then flags every out-of-sequence value.
- Maintains a saturating error count and reports wrap events; sits beside the counter in simulation and on-chip self-check.

Parameters:
- LOCK_CNT, 2, consecutive good decrements required in ACQUIRE before entering LOCKED (legal range 1..15).
- RST_VAL, 15, value the observed counter must present on a sample taken while it is held in reset.
- ERR_W, 8, width of err_count.

Ports:
- clk  input  1  system clock, rising edge.
- rst  input  1  synchronous, active-high reset of the checker.
- en  input  1  sample strobe; in0..in3 and dut_rst are sampled only on edges where en=1.
- dut_rst  input  1  the observed counter's reset, sampled with en.
- in0  input  1  counter bit 0 (LSB).
- in1  input  1  counter bit 1.
- in2  input  1  counter bit 2.
- in3  input  1  counter bit 3 (MSB).
- err_clr  input  1  synchronous clear of err_count.
- locked  output  1  high while in LOCKED.
- err  output  1  one-cycle pulse: mismatch detected while locked.
- wrap  output  1  one-cycle pulse: 0 -> 15 transition observed while locked.
- err_count  output  ERR_W  saturating count of err pulses.
- expected  output  4  value required at the next sample: prev-1 mod 16, or RST_VAL after a dut_rst sample.

Behaviour:
- Sampling and registers:
  - v = {in3,in2,in1,in0}.
  - All state and outputs are registered; err and wrap assert in the cycle after the sampling edge.
  - On any edge with en=0: FSM, prev and good_cnt hold; err=0 and wrap=0.
- Reset (rst=1, highest priority, takes effect at the next edge, including mid-acquire/mid-lock):
  - state=IDLE, prev=0, good_cnt=0, locked=0, err=0, wrap=0, err_count=0, expected=0.
- Match rule for a sample:
  - If dut_rst=1: match iff v==RST_VAL.
  - Otherwise: match iff v==expected.
  - A stalled value (v==prev) is a mismatch.
- After every sample: prev=v; expected = RST_VAL if dut_rst=1, else (v-1) mod 16 (0 -> 15).
- FSM states IDLE, ACQUIRE, LOCKED:
  - IDLE: first sample -> ACQUIRE, good_cnt=0; no match check.
  - ACQUIRE:
    - Match: good_cnt+1; if good_cnt+1==LOCK_CNT -> LOCKED, good_cnt=0.
    - Mismatch: good_cnt=0, stay in ACQUIRE.
    - err never pulses in ACQUIRE.
  - LOCKED:
    - Match: stay in LOCKED; wrap=1 if prev==0 and v==15 and dut_rst=0.
    - Mismatch: err=1, err_count increments, -> ACQUIRE, good_cnt=0.
- A dut_rst sample with v==RST_VAL while locked is a match: stays LOCKED, no wrap.
- err_count:
  - Saturates at 2^ERR_W-1.
  - err_clr=1 forces 0 on that edge and overrides a simultaneous increment; err still pulses.
  - Not affected by en.
- locked equals (state==LOCKED) and is registered with the state.

Test Plan:
- rst for 2 edges, then en=1 with v sequence 15,14,13,12 -> locked=1 after the third sample (the second good decrement); err=0 throughout; expected=11 after the sample 12.
- Locked, sequence 2,1,0,15,14 -> wrap=1 exactly one cycle after the sample 15; err=0; locked stays 1.
- Locked at v=9, next sample 9 (stall) -> err=1 for one cycle, err_count=1, locked=0. Then 8,7 -> locked=1 again; err_count stays 1.
- Locked at v=6, next sample v=15 with dut_rst=1 -> no err, locked=1, expected=15. Same with v=4 -> err=1, err_count+1.
- Force 260 mismatches (ERR_W=8) -> err_count stops at 255. err_clr coincident with a mismatch -> err_count=0 and err=1.
- Locked mid-sequence, assert rst one edge -> locked=0, err_count=0, expected=0. en=0 gap between samples 5 and 4 -> no error, lock retained.
